// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the arbiter, its four requesting ports and the core memory.
// The slave view belongs to the arbiter; the master view belongs to the ports plus memory.
interface mem_port_arbiter_if #(
   parameter int AW = 18,
   parameter int DW = 36
);
   logic [3:0]      port_sel;
   logic [3:0]      rq_cyc;
   logic [3:0]      rd_rq;
   logic [3:0]      wr_rq;
   logic [4*AW-1:0] ma;
   logic [4*DW-1:0] mb_wr;
   logic [3:0]      wr_rs;
   logic [3:0]      addr_ack;
   logic [3:0]      rd_rs;
   logic [DW-1:0]   mb_rd;
   logic            rmw_timeout;
   logic            busy;
   logic            mem_start;
   logic            mem_rd;
   logic            mem_wr;
   logic [AW-1:0]   mem_addr;
   logic            mem_wgo;
   logic [DW-1:0]   mem_wdata;
   logic            mem_rdone;
   logic [DW-1:0]   mem_rdata;
   logic            mem_wdone;

   modport slave (
      input  port_sel, rq_cyc, rd_rq, wr_rq, ma, mb_wr, wr_rs,
      input  mem_rdone, mem_rdata, mem_wdone,
      output addr_ack, rd_rs, mb_rd, rmw_timeout, busy,
      output mem_start, mem_rd, mem_wr, mem_addr, mem_wgo, mem_wdata
   );

   modport master (
      output port_sel, rq_cyc, rd_rq, wr_rq, ma, mb_wr, wr_rs,
      output mem_rdone, mem_rdata, mem_wdone,
      input  addr_ack, rd_rs, mb_rd, rmw_timeout, busy,
      input  mem_start, mem_rd, mem_wr, mem_addr, mem_wgo, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Four-port core-memory arbiter: fixed-priority grant, then sequences one memory cycle
// (address, read, optional read-modify-write pause, write) and hands results back.
module mem_port_arbiter #(
   parameter int AW         = 18,
   parameter int DW         = 36,
   parameter int WR_TIMEOUT = 64
) (
   input logic               clk,
   input logic               reset,
   mem_port_arbiter_if.slave bus
);
   localparam int CW = $clog2(WR_TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      READ,
      WAIT_WR,
      WRITE,
      RELEASE
   } state_t;

   state_t        state;
   logic [1:0]    grant;
   logic          rd_flag;
   logic          wr_flag;
   logic [CW-1:0] wait_cnt;
   logic [3:0]    req;
   logic [1:0]    pick;
   logic          any_req;

   // Port 0 has the highest priority, so scan downwards and let the lowest index win.
   always_comb begin
      req     = bus.rq_cyc & bus.port_sel;
      any_req = |req;
      pick    = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (req[i]) pick = 2'(i);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         grant           <= 2'd0;
         rd_flag         <= 1'b0;
         wr_flag         <= 1'b0;
         wait_cnt        <= '0;
         bus.addr_ack    <= '0;
         bus.rd_rs       <= '0;
         bus.mb_rd       <= '0;
         bus.rmw_timeout <= 1'b0;
         bus.busy        <= 1'b0;
         bus.mem_start   <= 1'b0;
         bus.mem_rd      <= 1'b0;
         bus.mem_wr      <= 1'b0;
         bus.mem_addr    <= '0;
         bus.mem_wgo     <= 1'b0;
         bus.mem_wdata   <= '0;
      end else begin
         // Every strobe is a single-cycle pulse unless re-armed below.
         bus.addr_ack    <= '0;
         bus.rd_rs       <= '0;
         bus.rmw_timeout <= 1'b0;
         bus.mem_start   <= 1'b0;
         bus.mem_rd      <= 1'b0;
         bus.mem_wr      <= 1'b0;
         bus.mem_wgo     <= 1'b0;

         case (state)
            IDLE: begin
               if (any_req) begin
                  grant         <= pick;
                  rd_flag       <= bus.rd_rq[pick];
                  wr_flag       <= bus.wr_rq[pick];
                  bus.mem_addr  <= bus.ma[int'(pick)*AW +: AW];
                  bus.mem_wdata <= bus.mb_wr[int'(pick)*DW +: DW];
                  bus.addr_ack  <= 4'b0001 << pick;
                  bus.mem_start <= bus.rd_rq[pick] | bus.wr_rq[pick];
                  bus.mem_rd    <= bus.rd_rq[pick];
                  bus.mem_wr    <= bus.wr_rq[pick] & ~bus.rd_rq[pick];
                  bus.mem_wgo   <= bus.wr_rq[pick] & ~bus.rd_rq[pick];
                  bus.busy      <= 1'b1;
                  state         <= ADDR;
               end
            end

            ADDR: begin
               if (rd_flag)      state <= READ;
               else if (wr_flag) state <= WRITE;
               else              state <= RELEASE;
            end

            READ: begin
               if (bus.mem_rdone) begin
                  bus.mb_rd <= bus.mem_rdata;
                  bus.rd_rs <= 4'b0001 << grant;
                  if (wr_flag) begin
                     wait_cnt <= CW'(WR_TIMEOUT);
                     state    <= WAIT_WR;
                  end else begin
                     state <= RELEASE;
                  end
               end
            end

            // A late requester gets its own data; otherwise the original word goes back.
            WAIT_WR: begin
               if (bus.wr_rs[grant]) begin
                  bus.mem_wdata <= bus.mb_wr[int'(grant)*DW +: DW];
                  bus.mem_wgo   <= 1'b1;
                  bus.mem_wr    <= 1'b1;
                  state         <= WRITE;
               end else if (wait_cnt <= CW'(1)) begin
                  wait_cnt        <= '0;
                  bus.mem_wdata   <= bus.mb_rd;
                  bus.mem_wgo     <= 1'b1;
                  bus.mem_wr      <= 1'b1;
                  bus.rmw_timeout <= 1'b1;
                  state           <= WRITE;
               end else begin
                  wait_cnt <= wait_cnt - CW'(1);
               end
            end

            WRITE: begin
               if (bus.mem_wdone) state <= RELEASE;
            end

            // Holding here until the request drops stops a held request being granted twice.
            RELEASE: begin
               if (!bus.rq_cyc[grant]) begin
                  bus.busy <= 1'b0;
                  state    <= IDLE;
               end
            end

            default: begin
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

   a_ack_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(bus.addr_ack));
   a_rdrs_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(bus.rd_rs));

endmodule
